// File: rtl/mem_router.sv
// mem_router: memory-map router from the load/store unit to ROM, RAM and byte-wide peripherals.
// Build option: define MEM_ROUTER_FAULT_EN to report unmapped, misaligned and illegal-store faults.

package mem_router_pkg;
   typedef enum logic [1:0] {
      write_byte     = 2'd0,
      write_halfword = 2'd1,
      write_word     = 2'd2
   } mem_width_t;
endpackage

module mem_router
   import mem_router_pkg::*;
#(
   parameter int unsigned     XLEN               = 32,
   parameter logic [XLEN-1:0] ROM_BASE           = 32'h0000,
   parameter int unsigned     ROM_LEN            = 32'h0800,
   parameter logic [XLEN-1:0] RAM_BASE           = 32'h0800,
   parameter int unsigned     RAM_LEN            = 32'h0400,
   parameter logic [XLEN-1:0] INPUT_PERIPH_BASE  = 32'h1000,
   parameter int unsigned     INPUT_PERIPH_LEN   = 16,
   parameter logic [XLEN-1:0] OUTPUT_PERIPH_BASE = 32'h1800,
   parameter int unsigned     OUTPUT_PERIPH_LEN  = 16
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_addr,
   input  logic            req_write,
   input  mem_width_t      req_wwidth,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_fault,
   output logic [XLEN-1:0] rom_addr,
   input  logic [XLEN-1:0] rom_rdata,
   output logic [XLEN-1:0] ram_addr,
   output mem_width_t      ram_wwidth,
   output logic            ram_wenable,
   output logic [XLEN-1:0] ram_wdata,
   input  logic [XLEN-1:0] ram_rdata,
   input  logic [7:0]      input_peripherals_mem  [INPUT_PERIPH_LEN],
   output logic [7:0]      output_peripherals_mem [OUTPUT_PERIPH_LEN]
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic [2:0] {TGT_NONE, TGT_ROM, TGT_RAM, TGT_IN, TGT_OUT} target_t;

   state_t          state, state_next;
   target_t         req_target, target_q;
   logic [XLEN-1:0] req_nbytes, out_offset, in_offset_q, out_offset_q, periph_data, load_data;
   logic            req_fault, req_store_ok, accept;
   logic [XLEN-1:0] addr_q;
   mem_width_t      width_q;
   logic            write_q, fault_q;
   logic            out_we    [OUTPUT_PERIPH_LEN];
   logic [7:0]      out_wbyte [OUTPUT_PERIPH_LEN];

   function automatic logic in_window(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] base,
                                      input int unsigned len);
      return (addr >= base) && ((addr - base) < XLEN'(len));
   endfunction

   always_comb begin
      req_target = TGT_NONE;
      if (in_window(req_addr, ROM_BASE, ROM_LEN))
         req_target = TGT_ROM;
      else if (in_window(req_addr, RAM_BASE, RAM_LEN))
         req_target = TGT_RAM;
      else if (in_window(req_addr, INPUT_PERIPH_BASE, INPUT_PERIPH_LEN))
         req_target = TGT_IN;
      else if (in_window(req_addr, OUTPUT_PERIPH_BASE, OUTPUT_PERIPH_LEN))
         req_target = TGT_OUT;
      case (req_wwidth)
         write_byte:     req_nbytes = XLEN'(1);
         write_halfword: req_nbytes = XLEN'(2);
         default:        req_nbytes = XLEN'(4);
      endcase
   end

`ifdef MEM_ROUTER_FAULT_EN
   logic [XLEN-1:0] region_base, region_len;

   // A store faults if any of its bytes would land past the end of its region.
   always_comb begin
      case (req_target)
         TGT_ROM: begin region_base = ROM_BASE;           region_len = XLEN'(ROM_LEN);           end
         TGT_RAM: begin region_base = RAM_BASE;           region_len = XLEN'(RAM_LEN);           end
         TGT_IN:  begin region_base = INPUT_PERIPH_BASE;  region_len = XLEN'(INPUT_PERIPH_LEN);  end
         TGT_OUT: begin region_base = OUTPUT_PERIPH_BASE; region_len = XLEN'(OUTPUT_PERIPH_LEN); end
         default: begin region_base = '0;                 region_len = '0;                       end
      endcase
      req_fault = (req_target == TGT_NONE)
               || ((req_nbytes == XLEN'(2)) && req_addr[0])
               || ((req_nbytes == XLEN'(4)) && (req_addr[1:0] != 2'b00))
               || (req_write && ((req_target == TGT_ROM)
                                 || ((req_addr - region_base + req_nbytes) > region_len)));
   end
`else
   assign req_fault = 1'b0;
`endif

   // Only RAM and output peripherals take stores; anything else is dropped.
   assign req_store_ok = req_write && !req_fault
                      && ((req_target == TGT_RAM) || (req_target == TGT_OUT));

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = ACCESS;
         end
         ACCESS: state_next = RESP;
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = req_ready && req_valid;

   assign rom_addr    = ((state == IDLE) ? req_addr : addr_q) - ROM_BASE;
   assign ram_addr    = ((state == IDLE) ? req_addr : addr_q) - RAM_BASE;
   assign ram_wwidth  = (state == IDLE) ? req_wwidth : width_q;
   assign ram_wdata   = req_wdata;
   assign ram_wenable = accept && req_store_ok && (req_target == TGT_RAM) && !reset;

   // Byte lane i of the store data lands on peripheral byte (offset + i) when that byte exists.
   always_comb begin
      out_offset = req_addr - OUTPUT_PERIPH_BASE;
      for (int j = 0; j < OUTPUT_PERIPH_LEN; j++) begin
         out_we[j]    = 1'b0;
         out_wbyte[j] = '0;
         for (int i = 0; i < 4; i++) begin
            if (accept && req_store_ok && (req_target == TGT_OUT) && (XLEN'(i) < req_nbytes)
                && ((out_offset + XLEN'(i)) == XLEN'(j))) begin
               out_we[j]    = 1'b1;
               out_wbyte[j] = req_wdata[8*i +: 8];
            end
         end
      end
   end

   // Peripheral loads gather four bytes from the latched offset; missing bytes read as zero.
   always_comb begin
      in_offset_q  = addr_q - INPUT_PERIPH_BASE;
      out_offset_q = addr_q - OUTPUT_PERIPH_BASE;
      periph_data  = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < INPUT_PERIPH_LEN; j++)
            if ((target_q == TGT_IN) && ((in_offset_q + XLEN'(i)) == XLEN'(j)))
               periph_data[8*i +: 8] = input_peripherals_mem[j];
         for (int j = 0; j < OUTPUT_PERIPH_LEN; j++)
            if ((target_q == TGT_OUT) && ((out_offset_q + XLEN'(i)) == XLEN'(j)))
               periph_data[8*i +: 8] = output_peripherals_mem[j];
      end
      case (target_q)
         TGT_ROM:         load_data = rom_rdata;
         TGT_RAM:         load_data = ram_rdata;
         TGT_IN, TGT_OUT: load_data = periph_data;
         default:         load_data = '0;
      endcase
      if (write_q || fault_q) load_data = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         addr_q     <= '0;
         width_q    <= write_byte;
         write_q    <= 1'b0;
         fault_q    <= 1'b0;
         target_q   <= TGT_NONE;
         resp_rdata <= '0;
         resp_fault <= 1'b0;
         for (int j = 0; j < OUTPUT_PERIPH_LEN; j++)
            output_peripherals_mem[j] <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            addr_q   <= req_addr;
            width_q  <= req_wwidth;
            write_q  <= req_write;
            fault_q  <= req_fault;
            target_q <= req_target;
         end
         if (state == ACCESS) begin
            resp_rdata <= load_data;
            resp_fault <= fault_q;
         end
         for (int j = 0; j < OUTPUT_PERIPH_LEN; j++)
            if (out_we[j]) output_peripherals_mem[j] <= out_wbyte[j];
      end
   end

endmodule

// File: tb/tb_mem_router.sv
// Self-checking bench for mem_router: directed scenarios plus randomized traffic
// compared against a byte-level memory-map model.

module tb_mem_router;
   import mem_router_pkg::*;

   localparam int R_NONE = 0;
   localparam int R_ROM  = 1;
   localparam int R_RAM  = 2;
   localparam int R_IN   = 3;
   localparam int R_OUT  = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   mem_width_t  req_wwidth;
   logic        resp_valid, resp_ready, resp_fault;
   logic [31:0] resp_rdata;
   logic [31:0] rom_addr, rom_rdata, ram_addr, ram_wdata, ram_rdata;
   mem_width_t  ram_wwidth;
   logic        ram_wenable;
   logic [7:0]  input_peripherals_mem  [16];
   logic [7:0]  output_peripherals_mem [16];

   logic [31:0] rom_words [512];
   logic [7:0]  ram_mem   [1024];
   logic [7:0]  ref_ram   [1024];
   logic [7:0]  ref_out   [16];
   logic        mem_init;

   int checks   = 0;
   int failures = 0;

   mem_router dut (
      .clock                  (clock),
      .reset                  (reset),
      .req_valid              (req_valid),
      .req_ready              (req_ready),
      .req_addr               (req_addr),
      .req_write              (req_write),
      .req_wwidth             (req_wwidth),
      .req_wdata              (req_wdata),
      .resp_valid             (resp_valid),
      .resp_ready             (resp_ready),
      .resp_rdata             (resp_rdata),
      .resp_fault             (resp_fault),
      .rom_addr               (rom_addr),
      .rom_rdata              (rom_rdata),
      .ram_addr               (ram_addr),
      .ram_wwidth             (ram_wwidth),
      .ram_wenable            (ram_wenable),
      .ram_wdata              (ram_wdata),
      .ram_rdata              (ram_rdata),
      .input_peripherals_mem  (input_peripherals_mem),
      .output_peripherals_mem (output_peripherals_mem)
   );

   always #5 clock = ~clock;

   function automatic int widthBytes(input mem_width_t w);
      case (w)
         write_byte:     return 1;
         write_halfword: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic [7:0] ramPattern(input int k);
      return 8'((k * 37 + 11) & 255);
   endfunction

   // Backing stores with one cycle of read latency.
   always @(posedge clock) begin
      rom_rdata <= rom_words[rom_addr[10:2]];
      if (mem_init) begin
         for (int k = 0; k < 1024; k++) ram_mem[k] <= ramPattern(k);
      end else if (ram_wenable) begin
         for (int k = 0; k < 4; k++)
            if (k < widthBytes(ram_wwidth)) ram_mem[10'(ram_addr[9:0] + 10'(k))] <= ram_wdata[8*k +: 8];
      end
      ram_rdata <= {ram_mem[10'(ram_addr[9:0] + 10'd3)], ram_mem[10'(ram_addr[9:0] + 10'd2)],
                    ram_mem[10'(ram_addr[9:0] + 10'd1)], ram_mem[ram_addr[9:0]]};
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkOutPeriph(input string tag);
      for (int q = 0; q < 4; q++)
         checkOutput(tag,
            {output_peripherals_mem[4*q+3], output_peripherals_mem[4*q+2],
             output_peripherals_mem[4*q+1], output_peripherals_mem[4*q]},
            {ref_out[4*q+3], ref_out[4*q+2], ref_out[4*q+1], ref_out[4*q]});
   endtask

   // Reference model: decides region, fault and load data, and applies store side effects.
   task automatic modelAccess(input logic [31:0] addr, input logic wr, input mem_width_t w,
                              input logic [31:0] wdata, output logic [31:0] exp_data,
                              output logic exp_fault, output logic exp_we);
      int nb, region, off, len;
      nb = widthBytes(w);
      region = R_NONE; off = 0; len = 0;
      if (addr < 32'h0800)                          begin region = R_ROM; off = int'(addr);            len = 2048; end
      else if (addr < 32'h0C00)                     begin region = R_RAM; off = int'(addr) - 32'h0800; len = 1024; end
      else if (addr >= 32'h1000 && addr < 32'h1010) begin region = R_IN;  off = int'(addr) - 32'h1000; len = 16;   end
      else if (addr >= 32'h1800 && addr < 32'h1810) begin region = R_OUT; off = int'(addr) - 32'h1800; len = 16;   end
      exp_fault = 1'b0;
`ifdef MEM_ROUTER_FAULT_EN
      if (region == R_NONE) exp_fault = 1'b1;
      if (nb == 2 && addr[0]) exp_fault = 1'b1;
      if (nb == 4 && addr[1:0] != 2'b00) exp_fault = 1'b1;
      if (wr && region == R_ROM) exp_fault = 1'b1;
      if (wr && region != R_NONE && off + nb > len) exp_fault = 1'b1;
`endif
      exp_we   = wr && !exp_fault && region == R_RAM;
      exp_data = 32'h0;
      if (wr && !exp_fault) begin
         for (int k = 0; k < nb; k++) begin
            if (region == R_RAM) ref_ram[(off + k) % 1024] = wdata[8*k +: 8];
            if (region == R_OUT && off + k < 16) ref_out[off + k] = wdata[8*k +: 8];
         end
      end else if (!wr && !exp_fault) begin
         for (int k = 0; k < 4; k++) begin
            case (region)
               R_RAM: exp_data[8*k +: 8] = ref_ram[(off + k) % 1024];
               R_IN:  exp_data[8*k +: 8] = (off + k < 16) ? input_peripherals_mem[off + k] : 8'h00;
               R_OUT: exp_data[8*k +: 8] = (off + k < 16) ? ref_out[off + k] : 8'h00;
               default: ;
            endcase
         end
         if (region == R_ROM) exp_data = rom_words[addr[10:2]];
      end
   endtask

   // One full transaction: accept, ACCESS, optional stalled RESP cycles, then handshake.
   task automatic applyStimulus(input logic [31:0] addr, input logic wr, input mem_width_t w,
                                input logic [31:0] wdata, input int stall);
      logic [31:0] exp_data;
      logic        exp_fault, exp_we;
      modelAccess(addr, wr, w, wdata, exp_data, exp_fault, exp_we);
      req_valid = 1'b1; req_addr = addr; req_write = wr; req_wwidth = w; req_wdata = wdata;
      resp_ready = 1'b0;
      #1;
      checkOutput("accept_req_ready", 32'(req_ready), 32'd1);
      checkOutput("accept_ram_wenable", 32'(ram_wenable), 32'(exp_we));
      checkOutput("accept_rom_addr", rom_addr, addr);
      checkOutput("accept_ram_addr", ram_addr, addr - 32'h0800);
      if (exp_we) begin
         checkOutput("accept_ram_wdata", ram_wdata, wdata);
         checkOutput("accept_ram_wwidth", 32'(ram_wwidth), 32'(w));
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      checkOutput("access_req_ready", 32'(req_ready), 32'd0);
      checkOutput("access_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("access_ram_wenable", 32'(ram_wenable), 32'd0);
      checkOutput("access_ram_addr", ram_addr, addr - 32'h0800);
      checkOutPeriph("access_out_periph");
      @(posedge clock); #1;
      for (int s = 0; s < stall; s++) begin
         req_valid = 1'b1; req_addr = 32'h0A00; req_write = 1'b1; req_wwidth = write_word;
         req_wdata = $urandom;
         #1;
         checkOutput("stall_resp_valid", 32'(resp_valid), 32'd1);
         checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
         checkOutput("stall_ram_wenable", 32'(ram_wenable), 32'd0);
         checkOutput("stall_rdata", resp_rdata, exp_data);
         checkOutput("stall_fault", 32'(resp_fault), 32'(exp_fault));
         @(posedge clock); #1;
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      #1;
      checkOutput("resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("resp_rdata", resp_rdata, exp_data);
      checkOutput("resp_fault", 32'(resp_fault), 32'(exp_fault));
      @(posedge clock); #1;
      resp_ready = 1'b0;
      checkOutput("post_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] addr, dummy_data;
      logic        dummy_fault, dummy_we, wr;
      mem_width_t  w;
      int          nb, bad;

      reset = 1'b1; mem_init = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wwidth = write_byte; req_wdata = '0;
      resp_ready = 1'b0;
      for (int k = 0; k < 512; k++) rom_words[k] = $urandom;
      rom_words[1] = 32'hDEADBEEF;
      for (int k = 0; k < 1024; k++) ref_ram[k] = ramPattern(k);
      for (int k = 0; k < 16; k++) begin
         ref_out[k] = 8'h00;
         input_peripherals_mem[k] = 8'($urandom);
      end
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
      checkOutput("reset_resp_fault", 32'(resp_fault), 32'd0);
      checkOutput("reset_ram_wenable", 32'(ram_wenable), 32'd0);
      checkOutPeriph("reset_out_periph");
      reset = 1'b0; mem_init = 1'b0;

      $display("[TB] directed scenarios");
      applyStimulus(32'h0004, 1'b0, write_word, 32'h0, 0);
      applyStimulus(32'h1801, 1'b1, write_byte, 32'h000000A5, 0);
      checkOutput("plan_out_byte1", 32'(output_peripherals_mem[1]), 32'h000000A5);
      applyStimulus(32'h1800, 1'b0, write_word, 32'h0, 0);
      applyStimulus(32'h0900, 1'b1, write_word, 32'h11223344, 0);
      checkOutput("plan_ram_word", {ram_mem[259], ram_mem[258], ram_mem[257], ram_mem[256]}, 32'h11223344);
      applyStimulus(32'h0010, 1'b1, write_word, 32'hCAFEF00D, 0);
      applyStimulus(32'h0802, 1'b0, write_word, 32'h0, 0);
      applyStimulus(32'h0C00, 1'b0, write_word, 32'h0, 0);
      applyStimulus(32'h0904, 1'b0, write_word, 32'h0, 5);

      $display("[TB] reset during response");
      modelAccess(32'h1800, 1'b1, write_byte, 32'h000000FF, dummy_data, dummy_fault, dummy_we);
      req_valid = 1'b1; req_addr = 32'h1800; req_write = 1'b1; req_wwidth = write_byte; req_wdata = 32'hFF;
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      checkOutput("rstresp_resp_valid_before", 32'(resp_valid), 32'd1);
      checkOutput("rstresp_out0_before", 32'(output_peripherals_mem[0]), 32'h000000FF);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int k = 0; k < 16; k++) ref_out[k] = 8'h00;
      checkOutput("rstresp_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rstresp_out0", 32'(output_peripherals_mem[0]), 32'd0);
      checkOutput("rstresp_req_ready", 32'(req_ready), 32'd1);
      applyStimulus(32'h1800, 1'b0, write_word, 32'h0, 1);

      $display("[TB] store accepted during reset");
      req_valid = 1'b1; req_addr = 32'h0A10; req_write = 1'b1; req_wwidth = write_word;
      req_wdata = 32'h55667788; reset = 1'b1;
      #1;
      checkOutput("rstacc_ram_wenable", 32'(ram_wenable), 32'd0);
      req_addr = 32'h1802; req_wwidth = write_byte; req_wdata = 32'h77;
      @(posedge clock); #1;
      req_valid = 1'b0; reset = 1'b0;
      checkOutput("rstacc_out2", 32'(output_peripherals_mem[2]), 32'd0);
      checkOutput("rstacc_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rstacc_resp_valid", 32'(resp_valid), 32'd0);

      $display("[TB] randomized traffic");
      for (int t = 0; t < 60; t++) begin
         for (int k = 0; k < 16; k++) input_peripherals_mem[k] = 8'($urandom);
         case ($urandom_range(0, 4))
            0: addr = 32'($urandom_range(0, 32'h07FF));
            1: addr = 32'h0800 + 32'($urandom_range(0, 32'h03FF));
            2: addr = 32'h1000 + 32'($urandom_range(0, 15));
            3: addr = 32'h1800 + 32'($urandom_range(0, 15));
            default: begin
               case ($urandom_range(0, 2))
                  0: addr = 32'h0C00 + 32'($urandom_range(0, 32'h03FF));
                  1: addr = 32'h1010 + 32'($urandom_range(0, 15));
                  default: addr = 32'h2000 + 32'($urandom_range(0, 32'h0FFF));
               endcase
            end
         endcase
         w  = mem_width_t'(2'($urandom_range(0, 2)));
         nb = widthBytes(w);
         if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(nb) - 32'd1);
         wr = 1'($urandom_range(0, 1));
         applyStimulus(addr, wr, w, $urandom, int'($urandom_range(0, 3)));
      end

      bad = 0;
      for (int k = 0; k < 1024; k++) if (ram_mem[k] !== ref_ram[k]) bad++;
      checkOutput("ram_contents", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
